// File: rtl/alu_sequencer_if.sv
// Host, ALU and result-consumer signals of the ALU micro-program sequencer.
// The sequencer takes the slave side; the host/ALU/consumer take the master side.
interface alu_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [20:0]       prog_data;
   logic              prog_err;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   run_len;
   logic              abort;
   logic              busy;
   logic              done;
   logic [3:0]        alu_opcode;
   logic [7:0]        alu_a;
   logic [7:0]        alu_b;
   logic [7:0]        alu_out;
   logic              res_valid;
   logic              res_ready;
   logic [7:0]        res_data;
   logic [ADDR_W-1:0] res_index;

   modport slave (
      input  prog_we, prog_addr, prog_data, start, start_addr, run_len, abort,
             alu_out, res_ready,
      output prog_err, busy, done, alu_opcode, alu_a, alu_b,
             res_valid, res_data, res_index
   );

   modport master (
      output prog_we, prog_addr, prog_data, start, start_addr, run_len, abort,
             alu_out, res_ready,
      input  prog_err, busy, done, alu_opcode, alu_a, alu_b,
             res_valid, res_data, res_index
   );
endinterface

// File: rtl/alu_sequencer.sv
// Issues a run of {chain, opcode, a, b} program words to the 8-bit ALU and
// returns each ALU result over a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start; program writes accepted
// ISSUE  | register operands of mem[pc] onto alu_*
// WAIT   | ALU_LATENCY cycles; result captured on the last edge
// OUTPUT | result held until consumer handshake
// DONE   | one-cycle done pulse, then back to IDLE
module alu_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_sequencer_if.slave   bus
);
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [3:0]          alu_opcode_q, alu_opcode_d;
   logic [7:0]          alu_a_q, alu_a_d;
   logic [7:0]          alu_b_q, alu_b_d;
   logic                res_valid_q, res_valid_d;
   logic [7:0]          res_data_q, res_data_d;
   logic [ADDR_W-1:0]   res_index_q, res_index_d;
   logic [7:0]          last_result_q, last_result_d;
   logic                prog_err_q, prog_err_d;
   logic [20:0]         mem [DEPTH];
   logic [20:0]         word;
   logic                idle;

   assign idle = (state_q == IDLE);
   assign word = mem[pc_q];

   // Program RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (bus.prog_we && idle) mem[bus.prog_addr] <= bus.prog_data;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      remaining_d   = remaining_q;
      wait_cnt_d    = wait_cnt_q;
      alu_opcode_d  = alu_opcode_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_index_d   = res_index_q;
      last_result_d = last_result_q;
      prog_err_d    = bus.prog_we && !idle;

      // Abort overrides everything, including a same-edge handshake or capture.
      if (bus.abort && !idle) begin
         state_d     = IDLE;
         res_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  pc_d        = bus.start_addr;
                  remaining_d = bus.run_len;
                  state_d     = (bus.run_len == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               alu_opcode_d = word[19:16];
               alu_a_d      = word[20] ? last_result_q : word[15:8];
               alu_b_d      = word[7:0];
               wait_cnt_d   = WAIT_W'(ALU_LATENCY - 1);
               state_d      = WAIT;
            end
            WAIT: begin
               if (wait_cnt_q == '0) begin
                  res_data_d    = bus.alu_out;
                  last_result_d = bus.alu_out;
                  res_index_d   = pc_q;
                  res_valid_d   = 1'b1;
                  state_d       = OUTPUT;
               end else begin
                  wait_cnt_d = wait_cnt_q - 1'b1;
               end
            end
            OUTPUT: begin
               if (res_valid_q && bus.res_ready) begin
                  res_valid_d = 1'b0;
                  pc_d        = pc_q + 1'b1;
                  remaining_d = remaining_q - 1'b1;
                  state_d     = (remaining_q == (ADDR_W+1)'(1)) ? DONE : ISSUE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         remaining_q   <= '0;
         wait_cnt_q    <= '0;
         alu_opcode_q  <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_index_q   <= '0;
         last_result_q <= '0;
         prog_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         remaining_q   <= remaining_d;
         wait_cnt_q    <= wait_cnt_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_index_q   <= res_index_d;
         last_result_q <= last_result_d;
         prog_err_q    <= prog_err_d;
      end
   end

   assign bus.busy       = !idle;
   assign bus.done       = (state_q == DONE);
   assign bus.prog_err   = prog_err_q;
   assign bus.alu_opcode = alu_opcode_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_index  = res_index_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: combinational ALU model, scoreboard of expected
// {index, data} pushed at start and popped at each result handshake.
module tb_alu_sequencer;
   localparam int ADDR_W = 4;
   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [7:0]        data;
   } exp_t;

   logic clk;
   logic rst_n;
   alu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   alu_sequencer #(.ADDR_W(ADDR_W), .ALU_LATENCY(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        sb [$];
   logic [20:0] tb_mem [16];
   logic [7:0]  model_last;
   int          n_chk, n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         default: return a & b;
      endcase
   endfunction

   assign bus.alu_out = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

   function automatic logic [20:0] mk(input logic c, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      return {c, op, a, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int addr, input logic [20:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = ADDR_W'(addr);
      bus.prog_data = data;
      tb_mem[addr]  = data;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   // Pulses start; when push is set the expected results go to the scoreboard.
   task automatic launch(input int addr, input int len, input bit push);
      logic [20:0] w;
      logic [7:0]  a, r;
      int          idx;
      exp_t        e;
      if (push) begin
         for (int i = 0; i < len; i++) begin
            idx = (addr + i) % 16;
            w   = tb_mem[idx];
            a   = w[20] ? model_last : w[15:8];
            r   = alu_f(w[19:16], a, w[7:0]);
            model_last = r;
            e.idx  = ADDR_W'(idx);
            e.data = r;
            sb.push_back(e);
         end
      end
      bus.start      = 1'b1;
      bus.start_addr = ADDR_W'(addr);
      bus.run_len    = (ADDR_W+1)'(len);
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && !bus.done; i++) tick();
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      tick();
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.res_valid && bus.res_ready && !bus.abort) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 32'(bus.res_data), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("res_data", 32'(bus.res_data), 32'(e.data));
            chk("res_index", 32'(bus.res_index), 32'(e.idx));
         end
      end
   end

   initial begin
      n_chk = 0; n_pass = 0; model_last = 8'h00;
      rst_n = 1'b0;
      bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
      bus.start = 0; bus.start_addr = '0; bus.run_len = '0;
      bus.abort = 0; bus.res_ready = 0;
      tick(); tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_valid", 32'(bus.res_valid), 0);
      chk("rst_alu_a", 32'(bus.alu_a), 0);
      chk("rst_prog_err", 32'(bus.prog_err), 0);
      rst_n = 1'b1;
      tick();

      // T1: latency, throughput, done timing
      write_word(0, mk(0, OP_ADD, 8'h0A, 8'h05));
      write_word(1, mk(0, OP_SUB, 8'h00, 8'h01));
      bus.res_ready = 1'b1;
      launch(0, 2, 1);
      chk("t1_busy", 32'(bus.busy), 1);
      tick();
      chk("t1_valid_e1", 32'(bus.res_valid), 0);
      tick();
      chk("t1_valid_e2", 32'(bus.res_valid), 1);
      chk("t1_data0", 32'(bus.res_data), 32'h0F);
      tick(); tick(); tick();
      chk("t1_valid_e5", 32'(bus.res_valid), 1);
      chk("t1_data1", 32'(bus.res_data), 32'hFF);
      tick();
      chk("t1_done", 32'(bus.done), 1);
      tick();
      chk("t1_done_pulse", 32'(bus.done), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // T2: chained A operand
      write_word(0, mk(0, OP_ADD, 8'd3, 8'd4));
      write_word(1, mk(1, OP_MUL, 8'h55, 8'd2));
      launch(0, 2, 1);
      wait_done("t2");
      chk("t2_last_chain", 32'(bus.res_data), 32'h0E);

      // T3: back-pressure holds result and operands
      write_word(0, mk(0, OP_ADD, 8'h0A, 8'h05));
      write_word(1, mk(0, OP_SUB, 8'h00, 8'h01));
      bus.res_ready = 1'b0;
      launch(0, 2, 1);
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("t3_valid", 32'(bus.res_valid), 1);
         chk("t3_data", 32'(bus.res_data), 32'h0F);
         chk("t3_alu_a", 32'(bus.alu_a), 32'h0A);
         chk("t3_alu_op", 32'(bus.alu_opcode), 32'(OP_ADD));
         tick();
      end
      bus.res_ready = 1'b1;
      wait_done("t3");

      // T4: address wrap and zero-length run
      write_word(15, mk(0, OP_ADD, 8'h01, 8'h01));
      launch(15, 2, 1);
      wait_done("t4");
      launch(0, 0, 0);
      chk("t4_len0_busy", 32'(bus.busy), 1);
      chk("t4_len0_done", 32'(bus.done), 1);
      chk("t4_len0_valid", 32'(bus.res_valid), 0);
      tick();
      chk("t4_len0_idle", 32'(bus.busy), 0);
      chk("t4_len0_done_end", 32'(bus.done), 0);

      // T5: abort in WAIT, then start/prog_we while busy
      launch(0, 1, 0);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t5_abort_busy", 32'(bus.busy), 0);
      chk("t5_abort_valid", 32'(bus.res_valid), 0);
      chk("t5_abort_done", 32'(bus.done), 0);
      launch(0, 1, 1);
      bus.start = 1'b1; bus.start_addr = 4'd5; bus.run_len = 5'd3;
      bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = mk(0, OP_SUB, 8'h77, 8'h01);
      tick();
      bus.start = 1'b0; bus.prog_we = 1'b0;
      chk("t5_prog_err", 32'(bus.prog_err), 1);
      tick();
      chk("t5_prog_err_pulse", 32'(bus.prog_err), 0);
      wait_done("t5");

      // T6: reset during OUTPUT
      bus.res_ready = 1'b0;
      launch(0, 1, 0);
      tick(); tick();
      chk("t6_in_output", 32'(bus.res_valid), 1);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", 32'(bus.res_valid), 0);
      chk("t6_rst_busy", 32'(bus.busy), 0);
      chk("t6_rst_data", 32'(bus.res_data), 0);
      chk("t6_rst_alu", 32'({bus.alu_opcode, bus.alu_a, bus.alu_b}), 0);
      chk("t6_rst_done", 32'(bus.done), 0);
      rst_n = 1'b1;
      model_last = 8'h00;
      bus.res_ready = 1'b1;
      write_word(1, mk(1, OP_ADD, 8'h00, 8'h09));
      launch(1, 1, 1);
      wait_done("t6");
      chk("t6_chain_after_rst", 32'(bus.res_data), 32'h09);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
